ps2_host_tx: RTL

//  Host-to-device PS/2 transmitter; the send side of the keyboard link whose receiver decodes scanSW.

---
 rtl/ps2_host_tx.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx - host-to-device PS/2 transmitter.
// Sends one command byte (e.g. ED + LED mask) to the keyboard over the shared
// open-drain clock/data pins using active-high pull-low enables.
// Optional feature macro: PS2_TX_RETRY_EN - when defined, a NACK or timeout
// restarts the frame from the inhibit phase with the same byte, up to 2 retries.
module ps2_host_tx #(
  parameter int CLK_HZ     = 24000000,
  parameter int INHIBIT_US = 120,
  parameter int START_MS   = 15,
  parameter int BIT_US     = 2000,
  parameter int FILT       = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int INH_CYC   = CLK_HZ / 1000000 * INHIBIT_US;
  localparam int START_CYC = CLK_HZ / 1000 * START_MS;
  localparam int BIT_CYC   = CLK_HZ / 1000000 * BIT_US;
  localparam int TW        = $clog2(START_CYC) + 1;
  localparam int FW        = $clog2(FILT) + 1;

  // INH plus the one-cycle request-to-send phase together hold the clock low
  // for exactly INH_CYC cycles, hence the load of INH_CYC-2.
  localparam logic [TW-1:0] INH_LOAD   = TW'(INH_CYC - 2);
  localparam logic [TW-1:0] START_LOAD = TW'(START_CYC);
  localparam logic [TW-1:0] BIT_LOAD   = TW'(BIT_CYC);
  localparam logic [FW-1:0] FILT_LAST  = FW'(FILT - 1);

  typedef enum logic [2:0] {IDLE, INH, RTS, SEND, ACK, WREL} state_t;

  state_t        state, next_state;
  logic [1:0]    sync1, sync2, filt;
  logic [FW-1:0] fcnt [2];
  logic          clk_f, data_f, clk_prev, fall;
  logic [8:0]    frame_q, shift;
  logic [3:0]    n;
  logic [TW-1:0] timer;
  logic          drive, nack, fail, accept, retry_left;

  assign clk_f  = filt[0];
  assign data_f = filt[1];
  assign fall   = clk_prev & ~clk_f;
  assign accept = tx_valid & tx_ready;

`ifdef PS2_TX_RETRY_EN
  logic [1:0] attempt;
  assign retry_left = (attempt != 2'd2);

  // Attempt counter: restarts on every accepted byte, steps on each retry.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)                    attempt <= 2'd0;
    else if (accept)              attempt <= 2'd0;
    else if (fail && retry_left)  attempt <= attempt + 2'd1;
  end
`else
  assign retry_left = 1'b0;
`endif

  // Synchronise both pins and only follow a level after FILT equal samples.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync1    <= 2'b11;
      sync2    <= 2'b11;
      filt     <= 2'b11;
      fcnt[0]  <= '0;
      fcnt[1]  <= '0;
      clk_prev <= 1'b1;
    end else begin
      sync1    <= {ps2_data_in, ps2_clk_in};
      sync2    <= sync1;
      clk_prev <= filt[0];
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FILT_LAST) begin
          filt[i] <= sync2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + FW'(1);
        end
      end
    end
  end

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic; a failed attempt either retries or ends the frame.
  always_comb begin
    next_state = state;
    fail       = 1'b0;
    case (state)
      IDLE: if (accept) next_state = INH;
      INH:  if (timer == '0) next_state = RTS;
      RTS:  next_state = SEND;
      SEND: begin
        if (fall) begin
          if (n == 4'd9) next_state = ACK;
        end else if (timer == '0) begin
          fail = 1'b1;
        end
      end
      ACK: begin
        if (fall)               next_state = WREL;
        else if (timer == '0)   fail = 1'b1;
      end
      WREL: begin
        if (clk_f && data_f) begin
          if (nack) fail = 1'b1;
          else      next_state = IDLE;
        end else if (timer == '0) begin
          fail = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
    if (fail) next_state = retry_left ? INH : IDLE;
  end

  // Frame datapath: byte latch, bit shifter, timeout timer, status flags.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      frame_q <= '0;
      shift   <= '0;
      n       <= '0;
      timer   <= '0;
      drive   <= 1'b0;
      nack    <= 1'b0;
      tx_err  <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      tx_done <= (state != IDLE) && (next_state == IDLE);
      case (state)
        IDLE: begin
          if (accept) begin
            frame_q <= {~^tx_data, tx_data};
            tx_err  <= 1'b0;
            nack    <= 1'b0;
            timer   <= INH_LOAD;
          end
        end
        INH: if (timer != '0) timer <= timer - TW'(1);
        RTS: begin
          timer <= START_LOAD;
          shift <= frame_q;
          n     <= '0;
          drive <= 1'b1;
        end
        SEND: begin
          if (fall) begin
            timer <= BIT_LOAD;
            n     <= n + 4'd1;
            if (n == 4'd9) begin
              drive <= 1'b0;
            end else begin
              drive <= ~shift[0];
              shift <= {1'b0, shift[8:1]};
            end
          end else if (timer != '0) begin
            timer <= timer - TW'(1);
          end
        end
        ACK: begin
          if (fall) begin
            timer <= BIT_LOAD;
            nack  <= data_f;
`ifndef PS2_TX_RETRY_EN
            tx_err <= data_f;
`endif
          end else if (timer != '0) begin
            timer <= timer - TW'(1);
          end
        end
        WREL: if (timer != '0) timer <= timer - TW'(1);
        default: ;
      endcase
      if (fail) begin
        if (retry_left) begin
          timer <= INH_LOAD;
          nack  <= 1'b0;
        end else begin
          tx_err <= 1'b1;
        end
      end
    end
  end

  // Pin enables and handshake derived from state; ready waits out the done cycle.
  always_comb begin
    tx_ready    = (state == IDLE) && !tx_done;
    busy        = (state != IDLE);
    ps2_clk_oe  = (state == INH) || (state == RTS);
    ps2_data_oe = (state == RTS) || ((state == SEND) && drive);
  end

endmodule
